// File: rtl/cvxif_compressed_sched_pkg.sv
// Shared types for the compressed-instruction scheduler: FSM states and
// captured request/response records.
package cvxif_sched_pkg;

  localparam int unsigned InstrCW  = 16;
  localparam int unsigned InstrXW  = 32;
  // Record fields are sized for the widest supported configuration.
  localparam int unsigned HartMaxW = 8;
  localparam int unsigned PortMaxW = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    RESP   = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic [InstrCW-1:0]  instr;
    logic [HartMaxW-1:0] hartid;
    logic [PortMaxW-1:0] port;
  } sched_req_t;

  typedef struct packed {
    logic                accept;
    logic [InstrXW-1:0]  instr;
    logic [HartMaxW-1:0] hartid;
    logic [PortMaxW-1:0] port;
  } sched_resp_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cvxif_compressed_sched_if.sv
// Issue-side, decoder-side and response-side signals of the scheduler.
// Handshakes: a transfer happens in a cycle where valid and ready are both 1;
// once valid is raised, its payload stays stable until that transfer cycle.
interface cvxif_compressed_sched_if
  import cvxif_sched_pkg::*;
#(
  parameter int unsigned NbReq   = 2,
  parameter int unsigned HartIdW = 2
);
  localparam int unsigned PortW = idx_width(NbReq);

  logic [NbReq-1:0]         req_valid_i;
  logic [NbReq*16-1:0]      req_instr_i;
  logic [NbReq*HartIdW-1:0] req_hartid_i;
  logic [NbReq-1:0]         req_ready_o;
  logic                     dec_valid_o;
  logic [15:0]              dec_instr_o;
  logic                     dec_ready_i;
  logic                     dec_accept_i;
  logic [31:0]              dec_instr_i;
  logic                     resp_valid_o;
  logic                     resp_ready_i;
  logic                     resp_accept_o;
  logic [31:0]              resp_instr_o;
  logic [HartIdW-1:0]       resp_hartid_o;
  logic [PortW-1:0]         resp_port_o;

  modport slave (
    input  req_valid_i, req_instr_i, req_hartid_i,
    input  dec_ready_i, dec_accept_i, dec_instr_i, resp_ready_i,
    output req_ready_o, dec_valid_o, dec_instr_o,
    output resp_valid_o, resp_accept_o, resp_instr_o, resp_hartid_o, resp_port_o
  );

  modport master (
    output req_valid_i, req_instr_i, req_hartid_i,
    output dec_ready_i, dec_accept_i, dec_instr_i, resp_ready_i,
    input  req_ready_o, dec_valid_o, dec_instr_o,
    input  resp_valid_o, resp_accept_o, resp_instr_o, resp_hartid_o, resp_port_o
  );

endinterface

// File: rtl/cvxif_rr_arbiter.sv
// Combinational round-robin grant; the search starts at the pointer, which
// moves just past the winner whenever the grant is taken.
module cvxif_rr_arbiter #(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    req_i,
  input  logic            advance_i,
  output logic [N-1:0]    grant_o,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;

  always_comb begin
    int unsigned k;
    k       = 0;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int unsigned o = 0; o < N; o++) begin
      k = (32'(ptr_q) + o) % N;
      if (!any_o && req_i[k]) begin
        any_o      = 1'b1;
        idx_o      = IdxW'(k);
        grant_o[k] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && any_o) begin
      ptr_d = (idx_o == IdxW'(N - 1)) ? '0 : idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/cvxif_compressed_sched.sv
// Serialises compressed-instruction requests from several issue ports onto one
// decoder: grant, registered decode request, then a held response.
module cvxif_compressed_sched
  import cvxif_sched_pkg::*;
#(
  parameter int unsigned NbReq   = 2,
  parameter int unsigned HartIdW = 2,
  parameter int unsigned CntW    = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  cvxif_compressed_sched_if.slave bus,
  output logic [CntW-1:0]        acc_cnt_o,
  output sched_state_e           dbg_state_o
);

  localparam int unsigned PortW = idx_width(NbReq);

  sched_state_e    state_q;
  sched_req_t      req_q;
  sched_resp_t     resp_q;
  logic            dec_valid_q;
  logic            resp_valid_q;
  logic [CntW-1:0] acc_cnt_q, acc_cnt_d;
  logic [NbReq-1:0] gnt;
  logic [PortW-1:0] gnt_idx;
  logic            gnt_any;
  logic            grant_fire;
  logic            unused_bits;

  assign grant_fire = (state_q == IDLE) && gnt_any && !flush_i;

  cvxif_rr_arbiter #(.N(NbReq), .IdxW(PortW)) u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (bus.req_valid_i),
    .advance_i(grant_fire),
    .grant_o  (gnt),
    .idx_o    (gnt_idx),
    .any_o    (gnt_any)
  );

  // Flush on the handshake cycle drops the response without counting it.
  always_comb begin
    acc_cnt_d = acc_cnt_q;
    if ((state_q == RESP) && bus.resp_ready_i && !flush_i && resp_q.accept &&
        (acc_cnt_q != '1)) begin
      acc_cnt_d = acc_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      req_q        <= '0;
      resp_q       <= '0;
      dec_valid_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      acc_cnt_q    <= '0;
    end else begin
      acc_cnt_q <= acc_cnt_d;
      if (flush_i) begin
        state_q      <= IDLE;
        req_q        <= '0;
        resp_q       <= '0;
        dec_valid_q  <= 1'b0;
        resp_valid_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (gnt_any) begin
              state_q      <= DECODE;
              dec_valid_q  <= 1'b1;
              req_q.instr  <= bus.req_instr_i[gnt_idx*16 +: 16];
              req_q.hartid <= HartMaxW'(bus.req_hartid_i[gnt_idx*HartIdW +: HartIdW]);
              req_q.port   <= PortMaxW'(gnt_idx);
            end
          end
          DECODE: begin
            if (bus.dec_ready_i) begin
              state_q       <= RESP;
              dec_valid_q   <= 1'b0;
              resp_valid_q  <= 1'b1;
              resp_q.accept <= bus.dec_accept_i;
              resp_q.instr  <= bus.dec_accept_i ? bus.dec_instr_i : '0;
              resp_q.hartid <= req_q.hartid;
              resp_q.port   <= req_q.port;
              req_q         <= '0;
            end
          end
          RESP: begin
            if (bus.resp_ready_i) begin
              state_q      <= IDLE;
              resp_valid_q <= 1'b0;
              resp_q       <= '0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.req_ready_o   = grant_fire ? gnt : '0;
  assign bus.dec_valid_o   = dec_valid_q;
  assign bus.dec_instr_o   = req_q.instr;
  assign bus.resp_valid_o  = resp_valid_q;
  assign bus.resp_accept_o = resp_q.accept;
  assign bus.resp_instr_o  = resp_q.instr;
  assign bus.resp_hartid_o = resp_q.hartid[HartIdW-1:0];
  assign bus.resp_port_o   = resp_q.port[PortW-1:0];
  assign acc_cnt_o         = acc_cnt_q;
  assign dbg_state_o       = state_q;
  assign unused_bits       = ^{resp_q.hartid, resp_q.port};

endmodule

// File: tb/tb_cvxif_compressed_sched.sv
// Directed bench for the compressed-instruction scheduler with a 2-bit
// accepted-instruction counter so saturation is reachable.
module tb_cvxif_compressed_sched;
  import cvxif_sched_pkg::*;

  localparam int unsigned NbReq   = 2;
  localparam int unsigned HartIdW = 2;
  localparam int unsigned CntW    = 2;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            flush_i;
  logic [CntW-1:0] acc_cnt_o;
  sched_state_e    dbg_state_o;

  int checks = 0;
  int errors = 0;
  logic [CntW-1:0] exp_cnt;

  cvxif_compressed_sched_if #(.NbReq(NbReq), .HartIdW(HartIdW)) bus ();

  cvxif_compressed_sched #(.NbReq(NbReq), .HartIdW(HartIdW), .CntW(CntW)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .bus        (bus),
    .acc_cnt_o  (acc_cnt_o),
    .dbg_state_o(dbg_state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic to_check();
    @(negedge clk_i);
  endtask

  task automatic set_port(input int p, input logic [15:0] instr, input logic [1:0] hid);
    bus.req_instr_i[p*16 +: 16]            = instr;
    bus.req_hartid_i[p*HartIdW +: HartIdW] = hid;
  endtask

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (v == {CntW{1'b1}}) ? v : v + 1'b1;
  endfunction

  initial begin
    rst_i            = 1'b1;
    flush_i          = 1'b0;
    bus.req_valid_i  = '0;
    bus.req_instr_i  = '0;
    bus.req_hartid_i = '0;
    bus.dec_ready_i  = 1'b0;
    bus.dec_accept_i = 1'b0;
    bus.dec_instr_i  = '0;
    bus.resp_ready_i = 1'b0;
    exp_cnt          = '0;
    #1;
    chk("rst_req_ready", bus.req_ready_o, 0);
    chk("rst_dec_valid", bus.dec_valid_o, 0);
    chk("rst_dec_instr", bus.dec_instr_o, 0);
    chk("rst_resp_valid", bus.resp_valid_o, 0);
    chk("rst_resp_instr", bus.resp_instr_o, 0);
    chk("rst_acc_cnt", acc_cnt_o, 0);
    chk("rst_state", dbg_state_o, IDLE);
    next_cycle();
    next_cycle();
    rst_i = 1'b0;

    // Single accepted request on port 0.
    set_port(0, 16'h4505, 2'd1);
    set_port(1, 16'h8082, 2'd2);
    bus.req_valid_i = 2'b01;
    to_check();
    chk("single_grant", bus.req_ready_o, 2'b01);
    next_cycle();
    bus.req_valid_i  = 2'b00;
    bus.dec_ready_i  = 1'b1;
    bus.dec_accept_i = 1'b1;
    bus.dec_instr_i  = 32'h00B50533;
    to_check();
    chk("single_dec_valid", bus.dec_valid_o, 1);
    chk("single_dec_instr", bus.dec_instr_o, 16'h4505);
    chk("single_no_grant", bus.req_ready_o, 0);
    next_cycle();
    bus.dec_ready_i  = 1'b0;
    bus.resp_ready_i = 1'b1;
    to_check();
    chk("single_resp_valid", bus.resp_valid_o, 1);
    chk("single_resp_instr", bus.resp_instr_o, 32'h00B50533);
    chk("single_resp_accept", bus.resp_accept_o, 1);
    chk("single_resp_hartid", bus.resp_hartid_o, 2'd1);
    chk("single_resp_port", bus.resp_port_o, 0);
    chk("single_cnt_before", acc_cnt_o, exp_cnt);
    exp_cnt = sat_inc(exp_cnt);
    next_cycle();
    bus.resp_ready_i = 1'b0;
    to_check();
    chk("single_resp_done", bus.resp_valid_o, 0);
    chk("single_cnt_after", acc_cnt_o, exp_cnt);
    chk("single_idle", dbg_state_o, IDLE);

    // Reject path; pointer is 1 but only port 0 requests.
    next_cycle();
    set_port(0, 16'h0001, 2'd3);
    bus.req_valid_i = 2'b01;
    to_check();
    chk("rej_grant", bus.req_ready_o, 2'b01);
    next_cycle();
    bus.req_valid_i  = 2'b00;
    bus.dec_ready_i  = 1'b1;
    bus.dec_accept_i = 1'b0;
    bus.dec_instr_i  = 32'hDEADBEEF;
    to_check();
    chk("rej_dec_instr", bus.dec_instr_o, 16'h0001);
    next_cycle();
    bus.dec_ready_i  = 1'b0;
    bus.resp_ready_i = 1'b1;
    to_check();
    chk("rej_resp_valid", bus.resp_valid_o, 1);
    chk("rej_resp_accept", bus.resp_accept_o, 0);
    chk("rej_resp_instr", bus.resp_instr_o, 0);
    chk("rej_resp_hartid", bus.resp_hartid_o, 2'd3);
    next_cycle();
    bus.resp_ready_i = 1'b0;
    to_check();
    chk("rej_cnt", acc_cnt_o, exp_cnt);
    chk("rej_resp_done", bus.resp_valid_o, 0);

    // Backpressure with both ports requesting; pointer is 1.
    next_cycle();
    set_port(0, 16'h4505, 2'd1);
    bus.req_valid_i = 2'b11;
    to_check();
    chk("bp_grant", bus.req_ready_o, 2'b10);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      bus.dec_ready_i = 1'b0;
      to_check();
      chk("bp_dec_valid", bus.dec_valid_o, 1);
      chk("bp_dec_instr", bus.dec_instr_o, 16'h8082);
      chk("bp_dec_no_grant", bus.req_ready_o, 0);
      chk("bp_dec_no_resp", bus.resp_valid_o, 0);
    end
    next_cycle();
    bus.dec_ready_i  = 1'b1;
    bus.dec_accept_i = 1'b1;
    bus.dec_instr_i  = 32'h00008067;
    to_check();
    chk("bp_dec_fire", bus.dec_valid_o, 1);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      bus.dec_ready_i  = 1'b0;
      bus.dec_instr_i  = 32'hFFFFFFFF;
      bus.resp_ready_i = 1'b0;
      to_check();
      chk("bp_resp_valid", bus.resp_valid_o, 1);
      chk("bp_resp_instr", bus.resp_instr_o, 32'h00008067);
      chk("bp_resp_accept", bus.resp_accept_o, 1);
      chk("bp_resp_hartid", bus.resp_hartid_o, 2'd2);
      chk("bp_resp_port", bus.resp_port_o, 1);
      chk("bp_resp_no_grant", bus.req_ready_o, 0);
    end
    next_cycle();
    bus.resp_ready_i = 1'b1;
    to_check();
    chk("bp_hs_valid", bus.resp_valid_o, 1);
    chk("bp_hs_no_grant", bus.req_ready_o, 0);
    exp_cnt = sat_inc(exp_cnt);
    next_cycle();
    bus.resp_ready_i = 1'b0;
    to_check();
    chk("bp_cnt", acc_cnt_o, exp_cnt);
    chk("bp_regrant", bus.req_ready_o, 2'b01);

    // Flush while in DECODE with the decoder answering in the same cycle.
    next_cycle();
    bus.req_valid_i  = 2'b00;
    flush_i          = 1'b1;
    bus.dec_ready_i  = 1'b1;
    bus.dec_accept_i = 1'b1;
    bus.dec_instr_i  = 32'h12345678;
    to_check();
    chk("fdec_dec_instr", bus.dec_instr_o, 16'h4505);
    chk("fdec_no_grant", bus.req_ready_o, 0);
    next_cycle();
    flush_i         = 1'b0;
    bus.dec_ready_i = 1'b0;
    to_check();
    chk("fdec_state", dbg_state_o, IDLE);
    chk("fdec_dec_valid", bus.dec_valid_o, 0);
    chk("fdec_resp_valid", bus.resp_valid_o, 0);
    chk("fdec_cnt", acc_cnt_o, exp_cnt);

    // Flush in RESP together with resp_ready; next grant follows pointer (1).
    next_cycle();
    bus.req_valid_i = 2'b11;
    to_check();
    chk("fresp_grant", bus.req_ready_o, 2'b10);
    next_cycle();
    bus.req_valid_i  = 2'b00;
    bus.dec_ready_i  = 1'b1;
    bus.dec_accept_i = 1'b1;
    bus.dec_instr_i  = 32'h00001111;
    to_check();
    chk("fresp_dec_valid", bus.dec_valid_o, 1);
    next_cycle();
    bus.dec_ready_i  = 1'b0;
    flush_i          = 1'b1;
    bus.resp_ready_i = 1'b1;
    to_check();
    chk("fresp_resp_valid", bus.resp_valid_o, 1);
    chk("fresp_resp_instr", bus.resp_instr_o, 32'h00001111);
    next_cycle();
    flush_i          = 1'b0;
    bus.resp_ready_i = 1'b0;
    to_check();
    chk("fresp_resp_done", bus.resp_valid_o, 0);
    chk("fresp_state", dbg_state_o, IDLE);
    chk("fresp_cnt", acc_cnt_o, exp_cnt);

    // Round robin with an always-ready decoder and consumer; pointer is 0.
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      bus.req_valid_i  = 2'b11;
      bus.dec_ready_i  = 1'b1;
      bus.dec_accept_i = 1'b1;
      bus.dec_instr_i  = 32'h00B50533;
      bus.resp_ready_i = 1'b1;
      to_check();
      if (c % 3 == 0) begin
        chk("rr_grant", bus.req_ready_o, ((c / 3) % 2 == 0) ? 2'b01 : 2'b10);
      end else begin
        chk("rr_no_grant", bus.req_ready_o, 0);
      end
      chk("rr_cnt", acc_cnt_o, exp_cnt);
      if (c % 3 == 2) begin
        chk("rr_resp_valid", bus.resp_valid_o, 1);
        chk("rr_resp_port", bus.resp_port_o, (c / 3) % 2);
        exp_cnt = sat_inc(exp_cnt);
      end
    end
    next_cycle();
    bus.req_valid_i  = 2'b00;
    bus.dec_ready_i  = 1'b0;
    bus.resp_ready_i = 1'b0;
    to_check();
    chk("sat_cnt", acc_cnt_o, 2'd3);
    chk("sat_state", dbg_state_o, IDLE);

    // Asynchronous reset in the middle of DECODE.
    next_cycle();
    bus.req_valid_i = 2'b01;
    to_check();
    chk("arst_grant", bus.req_ready_o, 2'b01);
    next_cycle();
    bus.req_valid_i = 2'b00;
    chk("arst_in_decode", dbg_state_o, DECODE);
    rst_i = 1'b1;
    #1;
    chk("arst_state", dbg_state_o, IDLE);
    chk("arst_dec_valid", bus.dec_valid_o, 0);
    chk("arst_dec_instr", bus.dec_instr_o, 0);
    chk("arst_resp_valid", bus.resp_valid_o, 0);
    chk("arst_cnt", acc_cnt_o, 0);
    next_cycle();
    next_cycle();
    rst_i = 1'b0;
    bus.req_valid_i = 2'b11;
    to_check();
    chk("arst_ptr_grant", bus.req_ready_o, 2'b01);
    chk("arst_resp_stays", bus.resp_valid_o, 0);

    next_cycle();
    bus.req_valid_i = 2'b00;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
